// File: rtl/kernel_bank.sv
// kernel_bank: double-buffered multi-kernel coefficient loader feeding a conv engine
// Ports: clk, reset (async, active-high); in_valid/in_ready/kernel_in coefficient stream;
//        clear aborts the shadow load; commit swaps shadow into active when load_done;
//        ch_sel picks the active kernel shown on out; out_valid once a bank is committed.
// Optional: define KERNEL_BANK_CHECKSUM_EN to add the checksum output (sum of the committed bank).
module kernel_bank #(
   parameter int BITS = 9,
   parameter int KERNEL_SIZE = 3,
   parameter int NUM_KERNELS = 4,
   localparam int KK = KERNEL_SIZE * KERNEL_SIZE,
   localparam int TOTAL = NUM_KERNELS * KK,
   localparam int CH_W = $clog2(NUM_KERNELS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BITS-1:0]      kernel_in,
   input  logic                 clear,
   input  logic                 commit,
   input  logic [CH_W-1:0]      ch_sel,
   output logic                 load_done,
   output logic                 out_valid,
   output logic [KK*BITS-1:0]   out
`ifdef KERNEL_BANK_CHECKSUM_EN
   ,
   output logic [BITS+$clog2(TOTAL):0] checksum
`endif
);
   localparam int IDX_W = $clog2(TOTAL);
   typedef enum logic {LOAD, FULL} state_t;
   state_t state, state_next;
   logic [IDX_W-1:0] wr_idx, wr_slot;
   logic [BITS-1:0] shadow [TOTAL];
   logic [BITS-1:0] active [TOTAL];
   logic [KK*BITS-1:0] sel;
   logic accept, last, swap;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= LOAD;
      else state <= state_next;
   // each kernel is filled back to front: first arrival lands in slot KK-1, last in slot 0
   always_comb begin
      in_ready = state == LOAD && !reset;
      load_done = state == FULL;
      accept = in_valid && in_ready;
      last = wr_idx == IDX_W'(TOTAL - 1);
      swap = state == FULL && commit && !clear;
      state_next = clear ? LOAD : (accept && last) ? FULL : swap ? LOAD : state;
      wr_slot = IDX_W'((32'(wr_idx) / KK) * KK + KK - 1 - 32'(wr_idx) % KK);
   end
   // ch_sel values with no matching kernel leave sel at zero
   always_comb begin
      sel = '0;
      for (int k = 0; k < NUM_KERNELS; k++)
         for (int s = 0; s < KK; s++)
            if (ch_sel == CH_W'(k)) sel[s*BITS +: BITS] = active[k*KK + s];
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_idx <= '0;
         shadow <= '{default: '0};
         active <= '{default: '0};
         out_valid <= 1'b0;
         out <= '0;
      end else begin
         out <= sel;
         if (clear) wr_idx <= '0;
         else if (accept) begin
            shadow[wr_slot] <= kernel_in;
            wr_idx <= last ? '0 : wr_idx + 1'b1;
         end else if (swap) begin
            active <= shadow;
            out_valid <= 1'b1;
         end
      end
`ifdef KERNEL_BANK_CHECKSUM_EN
   localparam int CS_W = BITS + $clog2(TOTAL) + 1;
   logic [CS_W-1:0] sum;
   // wr_idx == 0 on an accept marks the first coefficient of a new load
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sum <= '0;
         checksum <= '0;
      end else if (clear) sum <= '0;
      else if (accept) sum <= (wr_idx == '0 ? '0 : sum) + CS_W'(kernel_in);
      else if (swap) checksum <= sum;
`endif
endmodule

// File: tb/tb_kernel_bank.sv
// tb_kernel_bank: scoreboard bench for kernel_bank with a behavioural bank model
module tb_kernel_bank;
   localparam int BITS = 9;
   localparam int N = 4;
   localparam int KK = 9;
   localparam int TOTAL = 36;
   localparam int CH_W = 2;
   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, clear = 1'b0, commit = 1'b0;
   logic [BITS-1:0] kernel_in = '0;
   logic [CH_W-1:0] ch_sel = '0;
   logic in_ready, load_done, out_valid;
   logic [KK*BITS-1:0] out;
`ifdef KERNEL_BANK_CHECKSUM_EN
   logic [BITS+$clog2(TOTAL):0] checksum;
`endif
   kernel_bank #(.BITS(BITS), .KERNEL_SIZE(3), .NUM_KERNELS(N)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .kernel_in(kernel_in), .clear(clear), .commit(commit), .ch_sel(ch_sel),
      .load_done(load_done), .out_valid(out_valid), .out(out)
`ifdef KERNEL_BANK_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );
   typedef struct {
      logic [KK*BITS-1:0] o;
      bit ov, ld, ir;
      int cs;
   } exp_t;
   exp_t q[$];
   int checks = 0, failures = 0;
   int sh[N][KK], act[N][KK];
   int cnt = 0, sum = 0, cs = 0;
   bit full = 0, ov = 0;
   always #5 clk = ~clk;
   function automatic logic [KK*BITS-1:0] pick(int ch);
      logic [KK*BITS-1:0] r;
      r = '0;
      for (int s = 0; s < KK; s++) r[s*BITS +: BITS] = BITS'(act[ch][s]);
      return r;
   endfunction
   task automatic chk(string name, longint a, longint e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, a, e);
      end
   endtask
   task automatic model_step();
      exp_t e;
      if (reset) begin
         foreach (sh[k, s]) begin
            sh[k][s] = 0;
            act[k][s] = 0;
         end
         cnt = 0; sum = 0; cs = 0; full = 0; ov = 0;
         e.o = '0;
      end else begin
         e.o = pick(int'(ch_sel));
         if (clear) begin
            cnt = 0; full = 0; sum = 0;
         end else if (!full && in_valid) begin
            sh[cnt / KK][KK - 1 - cnt % KK] = int'(kernel_in);
            sum = (cnt == 0 ? 0 : sum) + int'(kernel_in);
            cnt++;
            if (cnt == TOTAL) begin
               cnt = 0; full = 1;
            end
         end else if (full && commit) begin
            act = sh; ov = 1; cs = sum; full = 0;
         end
      end
      e.ov = ov; e.ld = full; e.ir = !full; e.cs = cs;
      q.push_back(e);
   endtask
   always @(posedge clk) model_step();
   always @(negedge clk)
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("out", longint'(out), longint'(e.o));
         chk("out_valid", longint'(out_valid), longint'(e.ov));
         chk("load_done", longint'(load_done), longint'(e.ld));
         chk("in_ready", longint'(in_ready), longint'(e.ir));
`ifdef KERNEL_BANK_CHECKSUM_EN
         chk("checksum", longint'(checksum), longint'(e.cs));
`endif
      end
   task automatic cyc(bit v, int d, bit clr, bit cm, int ch);
      @(negedge clk);
      #1;
      in_valid = v; kernel_in = BITS'(d); clear = clr; commit = cm; ch_sel = CH_W'(ch);
   endtask
   task automatic settle();
      @(negedge clk);
      #2;
   endtask
   task automatic check_kernel(int ch, int base);
      cyc(0, 0, 0, 0, ch);
      settle();
      for (int i = 0; i < KK; i++)
         chk($sformatf("k%0d_slot%0d", ch, i), longint'(out[i*BITS +: BITS]), base - i);
   endtask
   task automatic load(int base, bit toggle, bit cm);
      int n;
      bit v;
      n = 0; v = 1;
      while (n < TOTAL) begin
         cyc(v, base + n, 0, cm, int'($urandom_range(0, N - 1)));
         if (v) n++;
         if (toggle) v = !v;
      end
   endtask
   task automatic check_sum(int e);
`ifdef KERNEL_BANK_CHECKSUM_EN
      chk("checksum_total", longint'(checksum), e);
`else
      if (e < 0) $display("unused %0d", e);
`endif
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end
   initial begin
      #2;
      chk("rst_out", longint'(out), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_load_done", longint'(load_done), 0);
      #5 reset = 1'b0;
      #1 chk("rst_in_ready", longint'(in_ready), 1);
      load(1, 0, 0);
      settle();
      chk("full_load_done", longint'(load_done), 1);
      chk("full_in_ready", longint'(in_ready), 0);
      chk("full_out_valid", longint'(out_valid), 0);
      cyc(0, 0, 0, 1, 0);
      check_kernel(0, 9);
      check_kernel(3, 36);
      chk("commit_out_valid", longint'(out_valid), 1);
      check_sum(666);
      load(100, 1, 1);
      repeat (3) cyc(1, 511, 0, 0, 0);
      settle();
      chk("bp_load_done", longint'(load_done), 1);
      for (int k = 0; k < N; k++) check_kernel(k, 9 * (k + 1));
      cyc(0, 0, 0, 1, 0);
      check_kernel(1, 117);
      check_sum(4230);
      for (int i = 0; i < 10; i++) cyc(1, 400 + i, 0, 0, 0);
      cyc(1, 450, 1, 1, 0);
      load(300, 0, 0);
      cyc(0, 0, 0, 1, 0);
      check_kernel(2, 326);
      check_kernel(0, 308);
      check_sum(11430);
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)), $urandom_range(0, 19) == 0,
             $urandom_range(0, 3) == 0, int'($urandom_range(0, N - 1)));
      cyc(1, 5, 0, 0, 0);
      cyc(1, 6, 0, 0, 0);
      @(negedge clk);
      #3;
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("async_out", longint'(out), 0);
      chk("async_out_valid", longint'(out_valid), 0);
      chk("async_load_done", longint'(load_done), 0);
      chk("async_in_ready", longint'(in_ready), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      load(1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      check_kernel(3, 36);
      repeat (2) cyc(0, 0, 0, 0, 0);
      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/kernel_bank.md
Name: kernel_bank

Overview:
- Multi-channel, double-buffered successor to the single-kernel serial loader.
- Serially loads NUM_KERNELS kernels of KERNEL_SIZE x KERNEL_SIZE coefficients into a shadow bank through a valid/ready handshake.
- An explicit commit swaps the shadow bank into the active bank in one cycle, so the conv datapath keeps reading stable kernels while the next set loads.
- The active kernel selected by ch_sel is presented flattened to the convolution engine.

Parameters:
- BITS, 9: coefficient width.
- KERNEL_SIZE, 3: kernel edge length; KK = KERNEL_SIZE*KERNEL_SIZE coefficients per kernel.
- NUM_KERNELS, 4: kernels per bank, >= 2. Localparams: TOTAL = NUM_KERNELS*KK; CH_W = $clog2(NUM_KERNELS).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  kernel_in holds a valid coefficient.
- in_ready  output  1  block accepts a coefficient this cycle.
- kernel_in  input  BITS  coefficient stream.
- clear  input  1  synchronous abort of the current shadow load.
- commit  input  1  request shadow-to-active swap.
- ch_sel  input  CH_W  kernel index to present on out.
- load_done  output  1  shadow bank full, awaiting commit.
- out_valid  output  1  active bank holds committed data.
- out  output  KK*BITS  selected active kernel, flattened.

Behaviour:
- Reset (async): shadow and active banks, wr_idx, out, out_valid and load_done = 0; state = LOAD; in_ready = 1 once reset deasserts.
- Accept occurs when in_valid && in_ready at a rising edge.
  - The coefficient goes to kernel c = wr_idx / KK, arrival n = wr_idx % KK.
  - It is stored at slot KK-1-n of that kernel: last-arrived coefficient at slot 0, first at slot KK-1, matching the previous loader's ordering.
  - wr_idx increments by 1.
- FSM:
  - LOAD: in_ready = 1, load_done = 0.
    - Accept at wr_idx == TOTAL-1 -> FULL and wr_idx = 0.
    - commit is ignored.
  - FULL: in_ready = 0, load_done = 1; in_valid is ignored.
    - commit -> on that edge the active bank takes the entire shadow bank, out_valid = 1 (sticky until reset), state -> LOAD.
- Shadow contents are retained after commit and overwritten by the next load.
- clear: wr_idx = 0, state -> LOAD, shadow contents untouched, active bank and out_valid untouched.
  - clear has priority over accept and commit in the same cycle.
- Last accept and commit in the same cycle: commit is ignored because the state was LOAD. A later commit is required.
- out is registered: out = active[ch_sel] one cycle after ch_sel or commit changes.
  - After a commit edge, out reflects the new bank at the following edge.
- ch_sel >= NUM_KERNELS (non-power-of-2 NUM_KERNELS): out = 0.
- Reset mid-load or mid-commit: everything returns to reset values. No partial swap is visible.
- No arithmetic on coefficients; values are stored bit-exact.

Optional Feature:
- Macro: KERNEL_BANK_CHECKSUM_EN.
- Defined:
  - Adds output checksum, width BITS+$clog2(TOTAL)+1.
  - A running unsigned sum of all accepted coefficients is kept for the shadow bank. It is zeroed by reset, by clear, and at the start of each new load (the first accept after FULL->LOAD).
  - On commit the running sum copies to checksum, in the same edge as the bank swap. Reset value is 0.
- Undefined: the port, the adder and the register are absent. All other behaviour is identical.

Test Plan (defaults BITS=9, K=3, N=4, TOTAL=36):
- Reset with in_valid=0 -> out=0, out_valid=0, load_done=0, in_ready=1.
- Stream values 1..36 with in_valid=1 every cycle:
  - load_done=1 and in_ready=0 the cycle after the 36th accept.
  - out_valid stays 0 until commit.
  - Commit, then ch_sel=0: slot i = 9-i. ch_sel=3: slot i = 36-i.
  - With the macro: checksum = 666.
- Back-pressure: toggle in_valid 1/0 and drive an extra coefficient while FULL -> exactly 36 accepts, the extra value never appears, and commit held high during LOAD has no effect.
- Double buffering: commit bank A (1..36), then load 100..135 without commit -> out for every ch_sel still shows bank A. Commit -> ch_sel=1 shows slot i = 117-i.
- Last accept and commit in the same cycle -> no swap, load_done=1. Commit one cycle later -> swap occurs.
- clear after 10 accepts, then 36 fresh accepts -> a correct bank from fresh data only. Reset asserted mid-load -> all outputs 0 immediately, without waiting for a clock edge.
